// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Brief  : Shared segment type, blank constant and hex-to-7-segment mapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Bit 7 = a ... bit 1 = g, bit 0 = h (decimal point); active-high.
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'h00;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 8'hFC;
            4'h1:    seg = 8'h60;
            4'h2:    seg = 8'hDA;
            4'h3:    seg = 8'hF2;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'hB6;
            4'h6:    seg = 8'hBE;
            4'h7:    seg = 8'hE0;
            4'h8:    seg = 8'hFE;
            4'h9:    seg = 8'hF6;
            4'hA:    seg = 8'hEE;
            4'hB:    seg = 8'h3E;
            4'hC:    seg = 8'h9C;
            4'hD:    seg = 8'h7A;
            4'hE:    seg = 8'h9E;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
// ============================================================================
// Module : seg7_hex_decoder
// Brief  : Combinational nibble + decimal point to active-high segment pattern.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dot,
    output seg_t       o_seg
);

    assign o_seg = hex_to_seg(i_nibble) | {7'b000_0000, i_dot};

endmodule

`default_nettype wire

// File: rtl/seg7_scan_n.sv
// ============================================================================
// Module : seg7_scan_n
// Brief  : Multiplexed N-digit hex seven-segment scanner with per-digit dots,
//          PWM brightness and frame-boundary (tear-free) input capture.
//          Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int CLK_MHZ     = 50,
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_HZ  = 1000,
    parameter int W_BRIGHT    = 3,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   number,
    input  logic [N_DIGITS-1:0]     dots,
    input  logic [W_BRIGHT-1:0]     brightness,
    output logic [7:0]              abcdefgh,
    output logic [N_DIGITS-1:0]     digit,
    output logic                    frame_done
);

    localparam int c_slot   = (CLK_MHZ * 1000000) / (REFRESH_HZ * N_DIGITS);
    localparam int c_div_w  = (c_slot > 2) ? $clog2(c_slot) : 1;
    localparam int c_on_w   = $clog2(c_slot + 1);
    localparam int c_idx_w  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_prod_w = W_BRIGHT + 1 + c_on_w;

    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(c_slot - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(N_DIGITS - 1);
    localparam seg_t                c_seg_mask = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] c_dig_mask = (DIG_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    generate
        if (c_slot < 2) begin : g_slot_check
            $error("seg7_scan_n: slot length %0d cycles is below 2", c_slot);
        end
        if ((N_DIGITS < 1) || (N_DIGITS > 8)) begin : g_ndig_check
            $error("seg7_scan_n: N_DIGITS %0d outside 1..8", N_DIGITS);
        end
    endgenerate

    logic [c_div_w-1:0]    r_div_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [4*N_DIGITS-1:0] r_shadow_num;
    logic [N_DIGITS-1:0]   r_shadow_dots;
    logic [c_on_w-1:0]     r_on_cycles;
    seg_t                  r_seg;
    logic [N_DIGITS-1:0]   r_dig;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [c_prod_w-1:0]   w_on_raw;
    logic [c_on_w-1:0]     w_on_now;
    logic [c_on_w-1:0]     w_on_eff;
    logic [3:0]            w_nibble;
    logic                  w_dot;
    seg_t                  w_dec_seg;
    seg_t                  w_pat;
    logic                  w_show;
    logic                  w_lit;
    logic [N_DIGITS-1:0]   w_onehot;

    assign w_slot_end  = (r_div_cnt == c_div_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);

    // Lit duration per slot: max(1, ((brightness+1)*SLOT) >> W_BRIGHT).
    assign w_on_raw = ((c_prod_w'(brightness) + c_prod_w'(1)) * c_prod_w'(c_slot)) >> W_BRIGHT;
    assign w_on_now = (w_on_raw == '0) ? c_on_w'(1) : w_on_raw[c_on_w-1:0];

    // Brightness is taken live on the first cycle of a slot, then held.
    assign w_on_eff = (r_div_cnt == '0) ? w_on_now : r_on_cycles;

    assign w_nibble = r_shadow_num[{r_idx, 2'b00} +: 4];
    assign w_dot    = r_shadow_dots[r_idx];
    assign w_onehot = N_DIGITS'(1) << r_idx;

    seg7_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .i_dot    (w_dot),
        .o_seg    (w_dec_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [c_idx_w-1:0] w_msd;
    logic               w_leading;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (r_shadow_num[4*i +: 4] != 4'h0) begin
                w_msd = c_idx_w'(i);
            end
        end
    end

    // A blanked leading digit still lights if its dot is set, showing the dot alone.
    assign w_leading = (r_idx > w_msd);
    assign w_show    = !w_leading || w_dot;
    assign w_pat     = w_leading ? {7'b000_0000, w_dot} : w_dec_seg;
`else
    assign w_show = 1'b1;
    assign w_pat  = w_dec_seg;
`endif

    assign w_lit = w_show && (c_on_w'(r_div_cnt) < w_on_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_idx         <= '0;
            r_shadow_num  <= '0;
            r_shadow_dots <= '0;
            r_on_cycles   <= '0;
            r_seg         <= SEG_OFF ^ c_seg_mask;
            r_dig         <= c_dig_mask;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;

            if (w_slot_end) begin
                r_div_cnt <= '0;
                r_idx     <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (r_div_cnt == '0) begin
                r_on_cycles <= w_on_now;
            end

            // Capture on the wrap edge so a frame never mixes old and new inputs.
            if (w_frame_end) begin
                r_shadow_num  <= number;
                r_shadow_dots <= dots;
            end

            // Segments and digit enable change together to avoid ghosting.
            r_seg <= (w_lit ? w_pat : SEG_OFF) ^ c_seg_mask;
            r_dig <= (w_lit ? w_onehot : '0) ^ c_dig_mask;
        end
    end

    assign abcdefgh   = r_seg;
    assign digit      = r_dig;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_n.sv
// ============================================================================
// Module : tb_seg7_scan_n
// Brief  : Directed self-checking bench for seg7_scan_n (SLOT=4, 4 digits, active-low).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] number;
    logic [3:0]  dots;
    logic [2:0]  brightness;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic        frame_done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    seg7_scan_n #(
        .CLK_MHZ     (1),
        .N_DIGITS    (4),
        .REFRESH_HZ  (62500),
        .W_BRIGHT    (3),
        .SEG_ACT_LOW (1),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .number     (number),
        .dots       (dots),
        .brightness (brightness),
        .abcdefgh   (abcdefgh),
        .digit      (digit),
        .frame_done (frame_done)
    );

    // Active-high abcdefg_ patterns, written out by hand.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'b1111_1100;
            4'h1: return 8'b0110_0000;
            4'h2: return 8'b1101_1010;
            4'h3: return 8'b1111_0010;
            4'h4: return 8'b0110_0110;
            4'h5: return 8'b1011_0110;
            4'h6: return 8'b1011_1110;
            4'h7: return 8'b1110_0000;
            4'h8: return 8'b1111_1110;
            4'h9: return 8'b1111_0110;
            4'hA: return 8'b1110_1110;
            4'hB: return 8'b0011_1110;
            4'hC: return 8'b1001_1100;
            4'hD: return 8'b0111_1010;
            4'hE: return 8'b1001_1110;
            default: return 8'b1000_1110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after the frame_done sample; checks the 16 cycles of one frame.
    task automatic check_frame(input string name, input logic [15:0] num, input logic [3:0] dts,
                               input int on, input int chg_at, input logic [15:0] chg_num);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] nib;
                logic       dt;
                logic [7:0] pat;
                logic       show;
                logic       lit;
                logic [3:0] ed;
                int         msd;
                if (s * 4 + c == chg_at) number = chg_num;
                tick;
                nib  = num[4*s +: 4];
                dt   = dts[s];
                pat  = hex7(nib) | {7'b0, dt};
                show = 1'b1;
                msd  = 0;
`ifdef SEG7_LZ_BLANK_EN
                for (int i = 1; i < 4; i++) if (num[4*i +: 4] != 4'h0) msd = i;
                if (s > msd) begin
                    if (dt) pat = 8'h01;
                    else show = 1'b0;
                end
`endif
                lit = show && (c < on);
                ed  = lit ? ~(4'b0001 << s) : 4'hF;
                chk($sformatf("%s dig s%0d c%0d", name, s, c), {4'h0, digit}, {4'h0, ed});
                if (lit) chk($sformatf("%s seg s%0d c%0d", name, s, c), abcdefgh, ~pat);
                chk($sformatf("%s fdone s%0d c%0d", name, s, c), {7'b0, frame_done},
                    {7'b0, (s == 3 && c == 3)});
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        number     = 16'h0000;
        dots       = 4'b0000;
        brightness = 3'd7;
        repeat (3) tick;
        chk("reset seg", abcdefgh, 8'hFF);
        chk("reset dig", {4'h0, digit}, 8'h0F);
        chk("reset fdone", {7'b0, frame_done}, 8'h00);

        number = 16'h12AF;
        dots   = 4'b0001;
        reset  = 1'b0;
        check_frame("f0_zero", 16'h0000, 4'b0000, 4, -1, 16'h0);
        check_frame("f1_12AF", 16'h12AF, 4'b0001, 4, -1, 16'h0);

        brightness = 3'd0;
        check_frame("f2_dim", 16'h12AF, 4'b0001, 1, 6, 16'h5678);

        brightness = 3'd3;
        number     = 16'h3BCD;
        dots       = 4'b1010;
        check_frame("f3_half", 16'h5678, 4'b0001, 2, -1, 16'h0);

        brightness = 3'd5;
        number     = 16'hE409;
        check_frame("f4_b5", 16'h3BCD, 4'b1010, 3, -1, 16'h0);

        // Reset asserted partway into slot 2.
        repeat (9) tick;
        reset = 1'b1;
        #1;
        chk("midreset seg", abcdefgh, 8'hFF);
        chk("midreset dig", {4'h0, digit}, 8'h0F);
        chk("midreset fdone", {7'b0, frame_done}, 8'h00);
        tick;
        chk("midreset hold dig", {4'h0, digit}, 8'h0F);
        reset = 1'b0;
        check_frame("f5_restart", 16'h0000, 4'b0000, 3, -1, 16'h0);
        check_frame("f6_E409", 16'hE409, 4'b1010, 3, -1, 16'h0);

`ifdef SEG7_LZ_BLANK_EN
        number = 16'h0005;
        dots   = 4'b0000;
        check_frame("lz_pre", 16'hE409, 4'b1010, 3, -1, 16'h0);
        number = 16'h0000;
        check_frame("lz_5", 16'h0005, 4'b0000, 3, -1, 16'h0);
        dots = 4'b1000;
        check_frame("lz_0", 16'h0000, 4'b0000, 3, -1, 16'h0);
        check_frame("lz_dot3", 16'h0000, 4'b1000, 3, -1, 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
